alu_exec_seq: RTL

Multi-cycle execution unit on the consuming side of the ALU control decoder: it takes the 4-bit ALU control code plus two 32-bit operands over a valid/ready handshake, executes the operation, and returns a registered result over a second valid/ready handshake. Logic ops complete in one cycle. Shifts run one bit per cycle. An optional shift-add multiplier runs 32 cycles. It sits in the EX stage of the RISC-V core and stalls the pipeline through `ready_o`/`valid_o`.

---
 rtl/alu_exec_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_seq.sv
// Multi-cycle EX-stage execution unit: one-cycle logic/arith, bit-serial shifts, optional shift-add MUL.
// Define ALU_EXEC_SEQ_MUL_EN to build the 32-cycle multiplier for code 1100; otherwise 1100 is illegal.
module alu_exec_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       alu_ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o,
  output logic [1:0]       state_o
);

  // Request handshake: accepted on a rising edge with valid_i & ready_o; result handshake completes
  // on a rising edge with valid_o & ready_i; ready_o is high only in IDLE and valid_o only in DONE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1011;
`ifdef ALU_EXEC_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1100;
`endif

  state_t           state_q, state_n;
  logic [WIDTH-1:0] result_q, result_n;
  logic             zero_q, zero_n;
  logic             illegal_q, illegal_n;
  logic [5:0]       cnt_q, cnt_n;
  logic [1:0]       op_q, op_n;
`ifdef ALU_EXEC_SEQ_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_n;
  logic [WIDTH-1:0] mplier_q, mplier_n;
  logic [WIDTH-1:0] mul_sum;
`endif

  logic [WIDTH-1:0] alu_res;
  logic             legal;
  logic             is_shift;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] shift_res;

  always_comb begin
    alu_res = '0;
    legal   = 1'b1;
    case (alu_ctrl_i)
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_ADD:  alu_res = src1_i + src2_i;
      OP_XOR:  alu_res = src1_i ^ src2_i;
      OP_SUB:  alu_res = src1_i - src2_i;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src1_i < src2_i};
      default: legal   = 1'b0;
    endcase
  end

  // Shift codes are 1000/1001/1010; the low two bits select SLL/SRL/SRA.
  assign is_shift = (alu_ctrl_i[3:2] == 2'b10) && (alu_ctrl_i[1:0] != 2'b11);
  assign shamt    = src2_i[4:0];

  always_comb begin
    case (op_q)
      2'b00:   shift_res = {result_q[WIDTH-2:0], 1'b0};
      2'b01:   shift_res = {1'b0, result_q[WIDTH-1:1]};
      default: shift_res = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
    endcase
  end

`ifdef ALU_EXEC_SEQ_MUL_EN
  assign mul_sum = mplier_q[0] ? (result_q + mcand_q) : result_q;
`endif

  always_comb begin
    state_n   = state_q;
    result_n  = result_q;
    zero_n    = zero_q;
    illegal_n = illegal_q;
    cnt_n     = cnt_q;
    op_n      = op_q;
`ifdef ALU_EXEC_SEQ_MUL_EN
    mcand_n   = mcand_q;
    mplier_n  = mplier_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          illegal_n = 1'b0;
          op_n      = alu_ctrl_i[1:0];
          if (is_shift) begin
            result_n = src1_i;
            if (shamt == 5'd0) begin
              zero_n  = (src1_i == '0);
              state_n = ST_DONE;
            end else begin
              cnt_n   = {1'b0, shamt};
              state_n = ST_SHIFT;
            end
          end
`ifdef ALU_EXEC_SEQ_MUL_EN
          else if (alu_ctrl_i == OP_MUL) begin
            mcand_n  = src1_i;
            mplier_n = src2_i;
            result_n = '0;
            cnt_n    = 6'd32;
            state_n  = ST_MUL;
          end
`endif
          else begin
            result_n  = alu_res;
            zero_n    = (alu_res == '0);
            illegal_n = ~legal;
            state_n   = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        result_n = shift_res;
        cnt_n    = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          zero_n  = (shift_res == '0);
          state_n = ST_DONE;
        end
      end
`ifdef ALU_EXEC_SEQ_MUL_EN
      ST_MUL: begin
        result_n = mul_sum;
        mcand_n  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_n = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_n    = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          zero_n  = (mul_sum == '0);
          state_n = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (ready_i) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      op_q      <= '0;
`ifdef ALU_EXEC_SEQ_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
`endif
    end else begin
      state_q   <= state_n;
      result_q  <= result_n;
      zero_q    <= zero_n;
      illegal_q <= illegal_n;
      cnt_q     <= cnt_n;
      op_q      <= op_n;
`ifdef ALU_EXEC_SEQ_MUL_EN
      mcand_q   <= mcand_n;
      mplier_q  <= mplier_n;
`endif
    end
  end

  assign ready_o   = (state_q == ST_IDLE);
  assign valid_o   = (state_q == ST_DONE);
  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign illegal_o = illegal_q;
  assign state_o   = state_q;

endmodule
